vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA sync generator. Samples active-low hsync/vsync and an active-high display-enable (blank, 1 = visible) on the pixel clock. Recovers the pixel coordinates of the visible region, measures line and frame period, and reports lock and timing errors. Used for loopback checking of the video output path and as the front end for any block that consumes a pixel stream plus sync.

---
 rtl/vga_sync_decoder_if.sv | 34 +++
 rtl/vga_sync_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync/blank pins in, decoded pixel timing out
interface vga_sync_decoder_if #(
  parameter int CNT_W = 11
);
  // Raw video timing pins (sync active low, blank = display enable)
  logic             hsync_in;
  logic             vsync_in;
  logic             blank_in;

  // Decoded stream position and timing status
  logic             pixel_valid;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
  logic             locked;
  logic [CNT_W-1:0] h_total;
  logic [CNT_W-1:0] v_total;
  logic             timing_err;

  // Video source side: drives the pins, observes the decode
  modport master (
    output hsync_in, vsync_in, blank_in,
    input  pixel_valid, x, y, line_start, frame_start,
    input  locked, h_total, v_total, timing_err
  );

  // Decoder side
  modport slave (
    input  hsync_in, vsync_in, blank_in,
    output pixel_valid, x, y, line_start, frame_start,
    output locked, h_total, v_total, timing_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync receiver: coordinates, line/frame measurement, lock tracking
module vga_sync_decoder #(
  parameter int CNT_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  vga_sync_decoder_if.slave   vid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Input stage: *_r is the registered pin, *_q the value one clock earlier
  logic hs_r, hs_q, vs_r, vs_q, bl_r, bl_q;

  // Edge strobes, valid for one cycle after the registered pin changes
  logic hs_fall, vs_fall, bl_rise, bl_fall;

  // Output registers
  logic             pixel_valid_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic [CNT_W-1:0] x_r;
  logic [CNT_W-1:0] y_r;
  logic             locked_r;
  logic             timing_err_r;
  logic [CNT_W-1:0] h_total_r;
  logic [CNT_W-1:0] v_total_r;

  // Line / frame measurement
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             hs_seen;
  logic             hcnt_sat;
  logic             line_ok;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] frame_len;

  // Lock tracking
  logic [1:0]       state;
  logic             consistent;
  logic [CNT_W-1:0] h_cand;
  logic             cons_nx;
  logic [CNT_W-1:0] cand_nx;
  logic             lock_err;

  // Register the pins and keep one clock of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r <= 1'b1;
      hs_q <= 1'b1;
      vs_r <= 1'b1;
      vs_q <= 1'b1;
      bl_r <= 1'b0;
      bl_q <= 1'b0;
    end else begin
      hs_r <= vid.hsync_in;
      hs_q <= hs_r;
      vs_r <= vid.vsync_in;
      vs_q <= vs_r;
      bl_r <= vid.blank_in;
      bl_q <= bl_r;
    end
  end

  assign hs_fall = hs_q & ~hs_r;
  assign vs_fall = vs_q & ~vs_r;
  assign bl_rise = ~bl_q & bl_r;
  assign bl_fall = bl_q & ~bl_r;

  // Pixel coordinates and sync pulses, one register after the edge strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid_r <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      x_r           <= '0;
      y_r           <= '0;
    end else begin
      pixel_valid_r <= bl_r;
      line_start_r  <= hs_fall;
      frame_start_r <= vs_fall;

      if (bl_rise) begin
        x_r <= '0;
      end else if (bl_r && x_r != CNT_MAX) begin
        x_r <= x_r + CNT_ONE;
      end

      if (vs_fall) begin
        y_r <= '0;
      end else if (bl_fall && y_r != CNT_MAX) begin
        y_r <= y_r + CNT_ONE;
      end
    end
  end

  // A line is only measurable when its opening hsync edge was seen and the
  // counter did not run out; a line of 2^CNT_W clocks or more is unmeasurable.
  assign hcnt_sat = (hcnt == CNT_MAX);
  assign line_ok  = hs_fall & hs_seen & ~hcnt_sat;
  assign line_len = hcnt + CNT_ONE;

  // A line closing on the same clock as vsync falls belongs to the ending frame
  assign frame_len = (line_ok && vcnt != CNT_MAX) ? vcnt + CNT_ONE : vcnt;

  // Clock-per-line and line-per-frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hs_seen <= 1'b0;
    end else begin
      if (hs_fall) begin
        hcnt <= '0;
      end else if (!hcnt_sat) begin
        hcnt <= hcnt + CNT_ONE;
      end

      if (hs_fall) begin
        hs_seen <= 1'b1;
      end else if (hcnt_sat) begin
        hs_seen <= 1'b0;
      end

      if (vs_fall) begin
        vcnt <= '0;
      end else if (line_ok && vcnt != CNT_MAX) begin
        vcnt <= vcnt + CNT_ONE;
      end
    end
  end

  // Candidate line length including a line that closes this very cycle
  always_comb begin
    cand_nx = h_cand;
    cons_nx = consistent;
    if (line_ok) begin
      if (h_cand == '0) begin
        cand_nx = line_len;
      end else if (line_len != h_cand) begin
        cons_nx = 1'b0;
      end
    end
  end

  assign lock_err = (line_ok && line_len != h_total_r)
                  || (vs_fall && frame_len != v_total_r)
                  || hcnt_sat;

  // Lock FSM: wait for a frame boundary, qualify one full frame, then police it
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SEARCH;
      consistent   <= 1'b0;
      h_cand       <= '0;
      h_total_r    <= '0;
      v_total_r    <= '0;
      locked_r     <= 1'b0;
      timing_err_r <= 1'b0;
    end else begin
      timing_err_r <= 1'b0;
      case (state)
        ST_SEARCH: begin
          locked_r <= 1'b0;
          if (vs_fall) begin
            state      <= ST_ACQUIRE;
            consistent <= 1'b1;
            h_cand     <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (vs_fall) begin
            if (cons_nx && cand_nx != '0 && frame_len != '0) begin
              h_total_r <= cand_nx;
              v_total_r <= frame_len;
              locked_r  <= 1'b1;
              state     <= ST_LOCKED;
            end
            consistent <= 1'b1;
            h_cand     <= '0;
          end else begin
            consistent <= cons_nx;
            h_cand     <= cand_nx;
          end
        end
        ST_LOCKED: begin
          if (lock_err) begin
            state        <= ST_SEARCH;
            locked_r     <= 1'b0;
            timing_err_r <= 1'b1;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign vid.pixel_valid = pixel_valid_r;
  assign vid.x           = x_r;
  assign vid.y           = y_r;
  assign vid.line_start  = line_start_r;
  assign vid.frame_start = frame_start_r;
  assign vid.locked      = locked_r;
  assign vid.h_total     = h_total_r;
  assign vid.v_total     = v_total_r;
  assign vid.timing_err  = timing_err_r;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized VGA timing against a pixel/line/frame reference
module tb_vga_sync_decoder;

  localparam int MAXC     = 2047;
  localparam int HS_W     = 3;
  localparam int HB       = 5;
  localparam int VS_LINES = 2;
  localparam int VB       = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_sync_decoder_if #(.CNT_W(11)) vif ();

  vga_sync_decoder #(.CNT_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int n = 0;

  // Timing of the current video mode
  int L, F, VW, VH, VS_OFF;

  // Pin samples taken at the previous two clock edges
  logic s1_hs = 1'b1, s1_vs = 1'b1, s1_bl = 1'b0;
  logic s2_hs = 1'b1, s2_vs = 1'b1, s2_bl = 1'b0;

  // Reference position: length of current visible run, visible runs since frame
  int run_len = 0, vis_runs = 0, exp_x = 0, exp_y = 0;

  // Observed event records
  int err_pulses, err_gap, err_with_ls, err_locked, last_ls, ls_count;
  int fs_count, fs_no_ls, lock_fs_idx, lock_with_fs, last_px_x, last_px_y;
  logic locked_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic clear_events();
    err_pulses  = 0;
    err_gap     = -1;
    err_with_ls = -1;
    err_locked  = -1;
    ls_count    = 0;
    fs_no_ls    = 0;
  endtask

  // One pixel clock: drive pins, then compare outputs with the reference
  task automatic tick(input logic hs, input logic vs, input logic bl, input logic r);
    logic e_pv, e_ls, e_fs;
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    vif.blank_in = bl;
    rst = r;
    @(posedge clk);
    #1;
    n++;
    if (r) begin
      e_pv = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
      run_len = 0; vis_runs = 0; exp_x = 0; exp_y = 0;
      fs_count = 0; lock_fs_idx = -1; lock_with_fs = -1;
    end else begin
      e_pv = s1_bl;
      e_ls = s2_hs & ~s1_hs;
      e_fs = s2_vs & ~s1_vs;
      if (s1_bl) begin
        run_len = s2_bl ? run_len + 1 : 1;
        exp_x = (run_len - 1 > MAXC) ? MAXC : run_len - 1;
      end
      if (e_fs) vis_runs = 0;
      else if (s2_bl && !s1_bl && vis_runs < MAXC) vis_runs++;
      exp_y = vis_runs;
    end
    check("pixel_valid", vif.pixel_valid, e_pv);
    check("x", vif.x, exp_x);
    check("y", vif.y, exp_y);
    check("line_start", vif.line_start, e_ls);
    check("frame_start", vif.frame_start, e_fs);

    if (vif.timing_err) begin
      err_pulses++;
      err_gap     = n - last_ls;
      err_with_ls = vif.line_start;
      err_locked  = vif.locked;
    end
    if (vif.line_start) begin
      last_ls = n;
      ls_count++;
    end
    if (vif.frame_start) begin
      fs_count++;
      if (!vif.line_start) fs_no_ls++;
    end
    if (vif.locked && !locked_prev) begin
      lock_fs_idx  = fs_count;
      lock_with_fs = vif.frame_start;
    end
    locked_prev = r ? 1'b0 : vif.locked;
    if (vif.pixel_valid) begin
      last_px_x = vif.x;
      last_px_y = vif.y;
    end

    if (r) begin
      s1_hs = 1'b1; s1_vs = 1'b1; s1_bl = 1'b0;
      s2_hs = 1'b1; s2_vs = 1'b1; s2_bl = 1'b0;
    end else begin
      s2_hs = s1_hs; s2_vs = s1_vs; s2_bl = s1_bl;
      s1_hs = hs;    s1_vs = vs;    s1_bl = bl;
    end
  endtask

  // One video line; extra stretches it, rst_p pulses reset at that pixel
  task automatic run_line(input int l, input int extra, input int rst_p);
    for (int p = 0; p < L + extra; p++) begin
      logic hs, vs, bl;
      hs = (p >= HS_W);
      vs = !((l == 0 && p >= VS_OFF) || (l > 0 && l < VS_LINES) || (l == VS_LINES && p < VS_OFF));
      bl = (l >= VB && l < VB + VH && p >= HB && p < HB + VW);
      tick(hs, vs, bl, p == rst_p);
      if (p == rst_p) begin
        check("rst_locked", vif.locked, 0);
        check("rst_h_total", vif.h_total, 0);
        check("rst_v_total", vif.v_total, 0);
        check("rst_timing_err", vif.timing_err, 0);
      end
    end
  endtask

  task automatic run_lines(input int first, input int last);
    for (int l = first; l <= last; l++) run_line(l, 0, -1);
  endtask

  task automatic run_frames(input int cnt);
    for (int f = 0; f < cnt; f++) run_lines(0, F - 1);
  endtask

  task automatic pick_params(input bit coincident);
    L      = $urandom_range(48, 28);
    VW     = $urandom_range(L - HB - 2, 4);
    F      = $urandom_range(16, 10);
    VH     = $urandom_range(F - VB - 2, 2);
    VS_OFF = coincident ? 0 : $urandom_range(L - 1, 1);
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_locked", vif.locked, 0);
    check("reset_h_total", vif.h_total, 0);
    check("reset_v_total", vif.v_total, 0);
    check("reset_timing_err", vif.timing_err, 0);
  endtask

  initial begin
    int k, d, ls_before;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    vif.blank_in = 1'b0;
    last_ls = 0;
    clear_events();

    // Steady-state lock from reset, sync edges apart
    pick_params(1'b0);
    do_reset();
    clear_events();
    run_frames(3);
    check("lock_locked", vif.locked, 1);
    check("lock_h_total", vif.h_total, L);
    check("lock_v_total", vif.v_total, F);
    check("lock_no_err", err_pulses, 0);
    check("lock_frame_idx", lock_fs_idx, 2);
    check("lock_with_fs", lock_with_fs, 1);
    check("last_px_x", last_px_x, VW - 1);
    check("last_px_y", last_px_y, VH - 1);

    // One stretched line while locked
    k = $urandom_range(F - 2, VS_LINES + 1);
    d = $urandom_range(8, 1);
    clear_events();
    run_lines(0, k - 1);
    run_line(k, d, -1);
    run_lines(k + 1, F - 1);
    run_frames(1);
    run_line(0, 0, -1);
    check("glitch_err_count", err_pulses, 1);
    check("glitch_err_gap", err_gap, L + d);
    check("glitch_err_with_ls", err_with_ls, 1);
    check("glitch_err_unlocked", err_locked, 0);
    check("glitch_relock", vif.locked, 1);
    check("glitch_h_total", vif.h_total, L);
    check("glitch_v_total", vif.v_total, F);
    run_lines(1, F - 1);

    // hsync missing for 3000 clocks while locked
    clear_events();
    run_lines(0, k);
    ls_before = ls_count;
    repeat (3000) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("gap_no_line_start", ls_count, ls_before);
    run_lines(k + 1, F - 1);
    run_frames(1);
    run_line(0, 0, -1);
    check("gap_err_count", err_pulses, 1);
    check("gap_err_gap", err_gap, MAXC + 1);
    check("gap_err_with_ls", err_with_ls, 0);
    check("gap_err_unlocked", err_locked, 0);
    check("gap_relock", vif.locked, 1);
    check("gap_v_total", vif.v_total, F);
    run_lines(1, F - 1);

    // Reset pulse in the middle of a locked frame
    clear_events();
    run_lines(0, k - 1);
    run_line(k, 0, L / 2);
    run_lines(k + 1, F - 1);
    run_frames(1);
    run_line(0, 0, -1);
    check("mrst_relock", vif.locked, 1);
    check("mrst_h_total", vif.h_total, L);
    check("mrst_v_total", vif.v_total, F);
    check("mrst_no_err", err_pulses, 0);
    run_lines(1, F - 1);

    // New mode with hsync and vsync falling on the same clock
    pick_params(1'b1);
    do_reset();
    clear_events();
    run_frames(3);
    check("coinc_locked", vif.locked, 1);
    check("coinc_h_total", vif.h_total, L);
    check("coinc_v_total", vif.v_total, F);
    check("coinc_no_err", err_pulses, 0);
    check("coinc_lock_idx", lock_fs_idx, 2);
    check("coinc_fs_count", fs_count, 3);
    check("coinc_fs_with_ls", fs_no_ls, 0);
    check("coinc_last_px_x", last_px_x, VW - 1);
    check("coinc_last_px_y", last_px_y, VH - 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
